// File: rtl/mdu_issue_ctrl.sv
// rtl/mdu_issue_ctrl.sv - divide/remainder issue controller between EX stage and iterative divider
//
// Purpose: accepts DIV/DIVU/REM/REMU (and W variants) from EX, resolves
// divide-by-zero and signed-overflow locally, otherwise issues the operation
// to the divider and holds it until div_finish, then writes back one cycle.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ex_start                 EX presents a valid divide/remainder instruction
//   ex_funct3, ex_word       operation select (100 DIV .. 111 REMU), W-variant
//   ex_rs1, ex_rs2, ex_rd    dividend, divisor, destination register
//   flush                    kill the in-flight operation
//   div_dividend/div_divisor operands toward the divider
//   div_opcode               {word, funct3[1:0], signed} toward the divider
//   div_ready                request to the divider
//   div_finish, div_rem_data divider done and its result
//   stall_req                hold IF/ID/EX
//   wb_valid, wb_rd, wb_data writeback
//   mdu_timeout              watchdog abort pulse
//
// Optional feature: define ysyx22040228_MDU_TIMEOUT_EN to enable an 8-bit
// watchdog on the REQ state; otherwise mdu_timeout is tied low.

module mdu_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_start,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_word,
    input  logic [63:0] ex_rs1,
    input  logic [63:0] ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        flush,
    output logic [63:0] div_dividend,
    output logic [63:0] div_divisor,
    output logic [3:0]  div_opcode,
    output logic        div_ready,
    input  logic        div_finish,
    input  logic [63:0] div_rem_data,
    output logic        stall_req,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic        mdu_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic        op_signed;
    logic        op_rem;
    logic [63:0] src_a;
    logic [63:0] src_b;
    logic        div_zero;
    logic        sgn_ovf;
    logic        shortcut;
    logic        accept;
    logic [63:0] short_raw;
    logic [63:0] short_res;
    logic [63:0] fin_res;
    logic        timeout_hit;

    // funct3[0] clear means signed, funct3[1] set means remainder.
    assign op_signed = ~ex_funct3[0];
    assign op_rem    = ex_funct3[1];

    // W variants operate on the low word, extended per signedness, so that
    // every later check and the divider itself see a consistent 64-bit value.
    assign src_a = ex_word ? {{32{op_signed & ex_rs1[31]}}, ex_rs1[31:0]} : ex_rs1;
    assign src_b = ex_word ? {{32{op_signed & ex_rs2[31]}}, ex_rs2[31:0]} : ex_rs2;

    assign div_zero = (src_b == 64'd0);
    assign sgn_ovf  = op_signed & (ex_word
                    ? ((src_a[31:0] == 32'h8000_0000) && (src_b[31:0] == 32'hFFFF_FFFF))
                    : ((src_a == 64'h8000_0000_0000_0000) && (src_b == 64'hFFFF_FFFF_FFFF_FFFF)));
    assign shortcut = div_zero | sgn_ovf;

    // funct3[2] distinguishes divide ops from multiplies on a shared bus.
    assign accept = (state == S_IDLE) & ex_start & ex_funct3[2] & ~flush;

    always_comb begin
        short_raw = 64'd0;
        if (div_zero) begin
            short_raw = op_rem ? src_a : 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            short_raw = op_rem ? 64'd0 : src_a;
        end
    end

    assign short_res = ex_word ? {{32{short_raw[31]}}, short_raw[31:0]} : short_raw;
    assign fin_res   = div_opcode[3] ? {{32{div_rem_data[31]}}, div_rem_data[31:0]}
                                     : div_rem_data;

`ifdef ysyx22040228_MDU_TIMEOUT_EN
    logic [7:0] to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= 8'd0;
        end else if (accept && !shortcut) begin
            to_cnt <= 8'd0;
        end else if (state == S_REQ) begin
            to_cnt <= to_cnt + 8'd1;
        end
    end

    assign timeout_hit = (state == S_REQ) & (to_cnt == 8'hFF) & ~div_finish;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdu_timeout <= 1'b0;
        end else begin
            mdu_timeout <= timeout_hit & ~flush;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign mdu_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = shortcut ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                // A flushed request may still be mid-handshake, so drain it.
                if (flush) begin
                    state_nxt = S_DRAIN;
                end else if (div_finish || timeout_hit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = div_finish ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (!div_finish) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_dividend <= 64'd0;
            div_divisor  <= 64'd0;
            div_opcode   <= 4'd0;
            wb_rd        <= 5'd0;
            wb_data      <= 64'd0;
        end else begin
            if (accept) begin
                div_dividend <= src_a;
                div_divisor  <= src_b;
                div_opcode   <= {ex_word, ex_funct3[1:0], op_signed};
                wb_rd        <= ex_rd;
                if (shortcut) begin
                    wb_data <= short_res;
                end
            end else if ((state == S_REQ) && !flush) begin
                if (div_finish) begin
                    wb_data <= fin_res;
                end else if (timeout_hit) begin
                    wb_data <= 64'hFFFF_FFFF_FFFF_FFFF;
                end
            end
        end
    end

    assign div_ready = (state == S_REQ);
    assign wb_valid  = (state == S_DONE);
    assign stall_req = (state == S_REQ) | (state == S_DRAIN) | ((state == S_IDLE) & ex_start);

endmodule
